// File: rtl/commutation_pkg.sv
// Shared constants, sine-sample type and elaboration-time sine generator for the
// N-phase sinusoidal commutation path.
package commutation_pkg;

  localparam int PHASES_DEF       = 3;
  localparam int DUTY_W_DEF       = 10;
  localparam int POS_W_DEF        = 13;
  localparam int CYCLE_COUNTS_DEF = 1170;
  localparam int DEAD_TIME_DEF    = 4;

  // Wide enough for table magnitudes up to DUTY_W = 16.
  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sine_t;

  // round(M*sin(2*pi*idx/counts)), M = 2^(duty_w-1)-1, rounded half away from zero.
  // Plain Taylor series after folding the angle into [-pi/2, pi/2].
  function automatic sine_t sine_entry(input int idx, input int counts, input int duty_w);
    real pi;
    real x;
    real term;
    real sum;
    real mag;
    int  m;
    int  r;
    pi = 3.14159265358979323846;
    x  = 2.0 * pi * real'(idx) / real'(counts);
    if (x > pi) x = x - 2.0 * pi;
    if (x > pi / 2.0) x = pi - x;
    else if (x < -pi / 2.0) x = -pi - x;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    m   = (1 << (duty_w - 1)) - 1;
    mag = real'(m) * sum;
    if (mag >= 0.0) r = $rtoi(mag + 0.5);
    else r = -$rtoi(0.5 - mag);
    return sine_t'(r);
  endfunction

endpackage

// File: rtl/sine_lut.sv
// CYCLE_COUNTS-entry sine ROM, contents fixed at elaboration, one registered read port.
module sine_lut
  import commutation_pkg::*;
#(
  parameter int CYCLE_COUNTS = CYCLE_COUNTS_DEF,
  parameter int DUTY_W       = DUTY_W_DEF,
  localparam int IDX_W       = $clog2(CYCLE_COUNTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] addr,
  output sine_t            data
);

  sine_t rom [CYCLE_COUNTS];

  for (genvar gi = 0; gi < CYCLE_COUNTS; gi++) begin : g_rom
    assign rom[gi] = sine_entry(gi, CYCLE_COUNTS, DUTY_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= '0;
    else data <= rom[addr];
  end

endmodule

// File: rtl/sine_commutator.sv
// N-phase sinusoidal commutator: position -> offset -> sine -> scale -> shadowed PWM.
// Optional complementary outputs with dead-time blanking under `DEAD_TIME_EN.
module sine_commutator
  import commutation_pkg::*;
#(
  parameter int PHASES       = PHASES_DEF,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int POS_W        = POS_W_DEF,
  parameter int CYCLE_COUNTS = CYCLE_COUNTS_DEF,
  parameter int DEAD_TIME    = DEAD_TIME_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] amplitude,
  input  logic [POS_W-1:0]  cycle_position,
  output logic [PHASES-1:0] pwm_high,
`ifdef DEAD_TIME_EN
  output logic [PHASES-1:0] pwm_low,
`endif
  output logic              period_start,
  output logic              position_fault
);

  localparam int IDX_W  = $clog2(CYCLE_COUNTS);
  localparam int OFFSET = CYCLE_COUNTS / PHASES;
  localparam int PROD_W = SAMPLE_W + DUTY_W + 1;
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;
  localparam logic [DUTY_W-1:0] MID     = DUTY_W'(1) << (DUTY_W - 1);

  if ((CYCLE_COUNTS % PHASES) != 0 || DEAD_TIME < 1 || DEAD_TIME > 15) begin : g_bad_params
    $error("sine_commutator: invalid PHASES/CYCLE_COUNTS/DEAD_TIME combination");
  end

  logic                           in_range;
  logic [IDX_W-1:0]               pos_sat;
  logic [IDX_W-1:0]               pos_reg;
  logic [PHASES-1:0][IDX_W-1:0]   idx_calc;
  logic [PHASES-1:0][IDX_W-1:0]   idx_reg;
  sine_t                          s_reg [PHASES];
  logic [PHASES-1:0][DUTY_W-1:0]  duty_calc;
  logic [PHASES-1:0][DUTY_W-1:0]  next_duty_reg;
  logic [PHASES-1:0][DUTY_W-1:0]  duty_reg;
  logic [DUTY_W-1:0]              cnt_reg;
  logic                           run_reg;
  logic [PHASES-1:0]              raw;

  // Out-of-range positions are clamped to the last valid count before anything else.
  assign in_range = (cycle_position < POS_W'(CYCLE_COUNTS));
  assign pos_sat  = in_range ? cycle_position[IDX_W-1:0] : IDX_W'(CYCLE_COUNTS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_reg        <= '0;
      position_fault <= 1'b0;
    end else begin
      pos_reg <= pos_sat;
      if (!in_range) position_fault <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
    logic [IDX_W:0]         sum;
    logic signed [PROD_W-1:0] prod;

    // pos < CYCLE_COUNTS, so one conditional subtract completes the modulo.
    assign sum = {1'b0, pos_reg} + (IDX_W + 1)'(gi * OFFSET);
    assign idx_calc[gi] = (sum >= (IDX_W + 1)'(CYCLE_COUNTS))
                        ? IDX_W'(sum - (IDX_W + 1)'(CYCLE_COUNTS))
                        : sum[IDX_W-1:0];

    sine_lut #(
      .CYCLE_COUNTS(CYCLE_COUNTS),
      .DUTY_W      (DUTY_W)
    ) u_lut (
      .clk  (clk),
      .reset(reset),
      .addr (idx_reg[gi]),
      .data (s_reg[gi])
    );

    assign prod          = PROD_W'(s_reg[gi]) * PROD_W'($signed({1'b0, amplitude}));
    assign duty_calc[gi] = MID + DUTY_W'(prod >>> DUTY_W);
    assign raw[gi]       = (cnt_reg < duty_reg[gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg       <= '0;
      next_duty_reg <= '0;
    end else begin
      idx_reg       <= idx_calc;
      next_duty_reg <= duty_calc;
    end
  end

  // Carrier and shadow duties. The first enabled clock parks cnt at 0 so the
  // period starts cleanly with the zero duties left over from the disabled state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg      <= 1'b0;
      cnt_reg      <= '0;
      period_start <= 1'b0;
      duty_reg     <= '0;
    end else if (!enable) begin
      run_reg      <= 1'b0;
      cnt_reg      <= '0;
      period_start <= 1'b0;
      duty_reg     <= '0;
    end else if (!run_reg) begin
      run_reg      <= 1'b1;
      cnt_reg      <= '0;
      period_start <= 1'b1;
    end else begin
      cnt_reg      <= cnt_reg + 1'b1;
      period_start <= (cnt_reg == CNT_MAX);
      if (cnt_reg == CNT_MAX) duty_reg <= next_duty_reg;
    end
  end

`ifdef DEAD_TIME_EN
  logic [PHASES-1:0]      raw_hold_reg;
  logic [PHASES-1:0][3:0] blank_reg;

  // Any change of raw blanks both sides; a change during blanking restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_high     <= '0;
      pwm_low      <= '0;
      raw_hold_reg <= '0;
      blank_reg    <= '0;
    end else begin
      for (int k = 0; k < PHASES; k++) begin
        if (!enable) begin
          pwm_high[k]     <= 1'b0;
          pwm_low[k]      <= 1'b0;
          raw_hold_reg[k] <= 1'b0;
          blank_reg[k]    <= '0;
        end else if (raw[k] != raw_hold_reg[k]) begin
          pwm_high[k]     <= 1'b0;
          pwm_low[k]      <= 1'b0;
          raw_hold_reg[k] <= raw[k];
          blank_reg[k]    <= 4'(DEAD_TIME - 1);
        end else if (blank_reg[k] != 4'd0) begin
          pwm_high[k]  <= 1'b0;
          pwm_low[k]   <= 1'b0;
          blank_reg[k] <= blank_reg[k] - 4'd1;
        end else begin
          pwm_high[k] <= raw_hold_reg[k];
          pwm_low[k]  <= ~raw_hold_reg[k];
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_high <= '0;
    else pwm_high <= enable ? raw : '0;
  end
`endif

endmodule

// File: tb/tb_sine_commutator.sv
// Randomized bench for sine_commutator: per-period high-time counts against a
// real-arithmetic sine reference, plus reset, enable and position-fault behaviour.
module tb_sine_commutator;

  localparam int PHASES = 3;
  localparam int DUTY_W = 10;
  localparam int POS_W  = 13;
  localparam int CC     = 1170;
  localparam int DT     = 4;
  localparam int PERIOD = 1 << DUTY_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [DUTY_W-1:0] amplitude;
  logic [POS_W-1:0]  cycle_position;
  logic [PHASES-1:0] pwm_high;
`ifdef DEAD_TIME_EN
  logic [PHASES-1:0] pwm_low;
`endif
  logic              period_start;
  logic              position_fault;

  int total = 0;
  int bad   = 0;
  int hi_cnt [PHASES];
  int lo_cnt [PHASES];
  int ps_cnt;
  int overlap;
  int fault_seen = 0;

  always #5 clk = ~clk;

  sine_commutator #(
    .PHASES      (PHASES),
    .DUTY_W      (DUTY_W),
    .POS_W       (POS_W),
    .CYCLE_COUNTS(CC),
    .DEAD_TIME   (DT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .amplitude     (amplitude),
    .cycle_position(cycle_position),
    .pwm_high      (pwm_high),
`ifdef DEAD_TIME_EN
    .pwm_low       (pwm_low),
`endif
    .period_start  (period_start),
    .position_fault(position_fault)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference duty straight from the sine/scale arithmetic.
  function automatic int ref_duty(input int pos, input int amp, input int k);
    int  p;
    int  idx;
    int  s;
    real x;
    p   = (pos >= CC) ? CC - 1 : pos;
    idx = (p + k * (CC / PHASES)) % CC;
    x   = 511.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / real'(CC));
    s   = (x >= 0.0) ? $rtoi($floor(x + 0.5)) : -$rtoi($floor(-x + 0.5));
    return 512 + $rtoi($floor(real'(s * amp) / 1024.0));
  endfunction

  function automatic int exp_high(input int d);
`ifdef DEAD_TIME_EN
    return (d == 0) ? 0 : d - DT;
`else
    return d;
`endif
  endfunction

  // Called at the negedge of a period_start cycle; ends at the next one.
  task automatic run_period(input int chg_at, input int new_pos, input int new_amp);
    ps_cnt  = 0;
    overlap = 0;
    for (int k = 0; k < PHASES; k++) begin
      hi_cnt[k] = 0;
      lo_cnt[k] = 0;
    end
    for (int i = 0; i < PERIOD; i++) begin
      if (i == chg_at) begin
        cycle_position = POS_W'(new_pos);
        amplitude      = DUTY_W'(new_amp);
      end
      for (int k = 0; k < PHASES; k++) begin
        hi_cnt[k] += int'(pwm_high[k]);
`ifdef DEAD_TIME_EN
        lo_cnt[k] += int'(pwm_low[k]);
        if (pwm_high[k] && pwm_low[k]) overlap++;
`endif
      end
      if (i > 0 && period_start) ps_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_period(input string tag, input int e0, input int e1, input int e2);
    int e [PHASES];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    for (int k = 0; k < PHASES; k++) begin
      check($sformatf("%s_ph%0d_high", tag, k), hi_cnt[k], exp_high(e[k]));
`ifdef DEAD_TIME_EN
      check($sformatf("%s_ph%0d_low", tag, k), lo_cnt[k], (e[k] == 0) ? PERIOD : PERIOD - e[k] - DT);
`endif
    end
`ifdef DEAD_TIME_EN
    check({tag, "_overlap"}, overlap, 0);
`endif
    check({tag, "_period_len"}, int'(period_start), 1);
    check({tag, "_extra_ps"}, ps_cnt, 0);
  endtask

  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    while (!period_start && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ps_seen"}, int'(period_start), 1);
  endtask

  initial begin
    int cur_pos;
    int cur_amp;
    int np;
    int na;
    int chg;
    int e0;
    int e1;
    int e2;
    int viol;
    bit first;

    reset          = 1'b1;
    enable         = 1'b0;
    amplitude      = '0;
    cycle_position = '0;
    repeat (3) @(negedge clk);
    check("rst_high", int'(pwm_high), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_fault", int'(position_fault), 0);

    reset = 1'b0;
    viol  = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm_high != '0 || period_start) viol++;
    end
    check("disabled_quiet", viol, 0);

    enable = 1'b1;
    wait_ps("enable");
    first   = 1'b1;
    cur_pos = 0;
    cur_amp = 0;

    for (int p = 0; p < 16; p++) begin
      case (p)
        0: begin np = 0;    na = 0;    chg = 100; end
        1: begin np = 0;    na = 1023; chg = 200; end
        2: begin np = 390;  na = 1023; chg = 500; end
        3: begin np = 1200; na = 1023; chg = 300; end
        4: begin np = 0;    na = 1023; chg = 50;  end
        15: begin np = 0;   na = 0;    chg = 600; end
        default: begin
          np  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, CC - 1))
                                           : int'($urandom_range(CC, (1 << POS_W) - 1));
          na  = int'($urandom_range(0, PERIOD - 1));
          chg = int'($urandom_range(10, 900));
        end
      endcase
      e0 = first ? 0 : ref_duty(cur_pos, cur_amp, 0);
      e1 = first ? 0 : ref_duty(cur_pos, cur_amp, 1);
      e2 = first ? 0 : ref_duty(cur_pos, cur_amp, 2);
      run_period(chg, np, na);
      if (np >= CC) fault_seen = 1;
      check_period($sformatf("p%0d", p), e0, e1, e2);
      check($sformatf("p%0d_fault", p), int'(position_fault), fault_seen);
      if (p == 2) begin
        check("amp1023_pos0_ph0", hi_cnt[0], exp_high(512));
        check("amp1023_pos0_ph1", hi_cnt[1], exp_high(954));
        check("amp1023_pos0_ph2", hi_cnt[2], exp_high(69));
      end
      if (p == 3) begin
        check("pos390_ph0", hi_cnt[0], exp_high(954));
        check("pos390_ph1", hi_cnt[1], exp_high(69));
        check("pos390_ph2", hi_cnt[2], exp_high(512));
      end
      if (p == 5) check("fault_sticky", int'(position_fault), 1);
      cur_pos = np;
      cur_amp = na;
      first   = 1'b0;
    end

    // Duty 512 on every phase now; hit reset in the middle of the high time.
    repeat (300) @(negedge clk);
    check("pre_reset_high", int'(pwm_high), 7);
    #2 reset = 1'b1;
    #1;
    check("async_rst_high", int'(pwm_high), 0);
    check("async_rst_ps", int'(period_start), 0);
    check("async_rst_fault", int'(position_fault), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ps("post_reset");
    run_period(-1, 0, 0);
    check_period("post_reset_first", 0, 0, 0);
    run_period(-1, 0, 0);
    check_period("post_reset_second", 512, 512, 512);
    check("post_reset_fault", int'(position_fault), 0);

    repeat (100) @(negedge clk);
    enable = 1'b0;
    viol   = 0;
    repeat (50) begin
      @(negedge clk);
      if (pwm_high != '0 || period_start) viol++;
    end
    check("disable_quiet", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
